// File: rtl/graphic_multi_pipe_pkg.sv
// ---------------------------------------------------------------------------
// graphic_pkg
// Shared types and constants for the pipelined multi-ball pixel renderer.
//   rgb12_t     : 12-bit colour, 4 bits each of red, green, blue (r in MSBs)
//   rgb_split_t : the same colour broken out into separate r/g/b fields
//   DX_W, DY_W  : widths of the signed horizontal/vertical centre offsets
//   DIST_W      : width of the squared distance, wide enough that the
//                 worst-case offsets never truncate
//   split_rgb() : unpacks an rgb12_t into its three channels
// ---------------------------------------------------------------------------
package graphic_pkg;

   typedef logic [11:0] rgb12_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_split_t;

   localparam int DX_W   = 12;
   localparam int DY_W   = 11;
   localparam int DIST_W = 24;

   // Breaks a packed 12-bit colour into the three channel nibbles
   function automatic rgb_split_t split_rgb(input rgb12_t c);
      rgb_split_t s;
      s.r = c[11:8];
      s.g = c[7:4];
      s.b = c[3:0];
      return s;
   endfunction

endpackage

// File: rtl/graphic_multi_pipe_ball_hit_test.sv
// ---------------------------------------------------------------------------
// ball_hit_test
// Purely combinational "is this pixel inside ball i" test, fed from the
// registered stage-1 offsets of the renderer.
//   en_i        : registered per-ball draw enable
//   dx_i        : signed pixel-minus-centre x offset (DX_W bits)
//   dy_i        : signed pixel-minus-centre y offset (DY_W bits)
//   in_circle_o : high when enabled and dx^2 + dy^2 <= BALL_RADIUS^2
// ---------------------------------------------------------------------------
module ball_hit_test
   import graphic_pkg::*;
#(
   parameter int BALL_RADIUS = 20
)
(
   input  logic                   en_i,
   input  logic signed [DX_W-1:0] dx_i,
   input  logic signed [DY_W-1:0] dy_i,
   output logic                   in_circle_o
);

   localparam logic [DIST_W-1:0] RADIUS_SQ = DIST_W'(BALL_RADIUS * BALL_RADIUS);

   logic [DX_W-1:0]   absX;
   logic [DY_W-1:0]   absY;
   logic [DIST_W-1:0] extX;
   logic [DIST_W-1:0] extY;
   logic [DIST_W-1:0] distSq;

   // Squaring the magnitude rather than the signed value keeps the whole
   // sum unsigned. The most negative offset still has a representable
   // magnitude because the magnitude is read back as an unsigned number.
   // Both magnitudes are widened before multiplying so nothing is lost.
   always_comb begin
      absX        = dx_i[DX_W-1] ? DX_W'(~dx_i + 1'b1) : DX_W'(dx_i);
      absY        = dy_i[DY_W-1] ? DY_W'(~dy_i + 1'b1) : DY_W'(dy_i);
      extX        = DIST_W'(absX);
      extY        = DIST_W'(absY);
      distSq      = (extX * extX) + (extY * extY);
      in_circle_o = en_i && (distSq <= RADIUS_SQ);
   end

endmodule

// File: rtl/graphic_multi_pipe.sv
// ---------------------------------------------------------------------------
// graphic_multi_pipe
// Two-stage pipelined renderer that paints up to N_BALLS circles, with fixed
// priority (lowest index on top), over a safe-zone / background map.
//   i_clk, i_rst_n          : pixel clock, async active-low reset
//   i_disp_enbl, i_hsync,
//   i_vsync                 : timing-generator controls, re-emitted 2 cycles late
//   i_h_coord, i_v_coord    : current pixel coordinate
//   o_screen_x, o_screen_y  : safe-map address (combinational from the coordinate)
//   i_is_safe               : safe-map data, one cycle after its address
//   i_ball_en/_x/_y         : per-ball enable and packed centre coordinates
//   o_red/o_green/o_blue    : registered pixel colour
//   o_hsync/o_vsync/
//   o_disp_enbl             : delayed controls, aligned with the colour
//   o_safe_hit              : per-ball "touched a safe pixel" for the last frame
//   o_frame_done            : one-cycle pulse when o_safe_hit is refreshed
// ---------------------------------------------------------------------------
module graphic_multi_pipe
   import graphic_pkg::*;
#(
   parameter int                    SCREEN_WIDTH  = 800,
   parameter int                    SCREEN_HEIGHT = 600,
   parameter int                    N_BALLS       = 4,
   parameter int                    BALL_RADIUS   = 20,
   // Ball 0 sits in the least significant 12 bits: red, yellow, magenta, cyan
   parameter logic [N_BALLS*12-1:0] BALL_COLORS   = {12'h0FF, 12'hF0F, 12'hFF0, 12'hF00},
   parameter rgb12_t                SAFE_COLOR    = 12'h0F0,
   parameter rgb12_t                BKG_COLOR     = 12'h00F,
   localparam int                   XW            = $clog2(SCREEN_WIDTH),
   localparam int                   YW            = $clog2(SCREEN_HEIGHT)
)
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_disp_enbl,
   input  logic [10:0]           i_h_coord,
   input  logic [9:0]            i_v_coord,
   input  logic                  i_hsync,
   input  logic                  i_vsync,
   output logic [XW-1:0]         o_screen_x,
   output logic [YW-1:0]         o_screen_y,
   input  logic                  i_is_safe,
   input  logic [N_BALLS-1:0]    i_ball_en,
   input  logic [N_BALLS*XW-1:0] i_ball_x,
   input  logic [N_BALLS*YW-1:0] i_ball_y,
   output logic [3:0]            o_red,
   output logic [3:0]            o_green,
   output logic [3:0]            o_blue,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic                  o_disp_enbl,
   output logic [N_BALLS-1:0]    o_safe_hit,
   output logic                  o_frame_done
);

   localparam logic [10:0] LAST_H = 11'(SCREEN_WIDTH - 1);
   localparam logic [9:0]  LAST_V = 10'(SCREEN_HEIGHT - 1);

   logic [N_BALLS-1:0][DX_W-1:0] dx_d, dx_q;
   logic [N_BALLS-1:0][DY_W-1:0] dy_d, dy_q;
   logic [N_BALLS-1:0]           ballEn_q;
   logic                         lastPix_d, lastPix_q;
   logic                         disp1_q, hsync1_q, vsync1_q;

   logic [N_BALLS-1:0]           inCircle;
   logic [N_BALLS-1:0]           hit;
   rgb12_t                       color_d, color_q;
   logic                         disp2_q, hsync2_q, vsync2_q;
   logic [N_BALLS-1:0]           acc_q;
   logic [N_BALLS-1:0]           safeHit_q;
   logic                         frameDone_q;
   rgb_split_t                   colorSplit;

   // The safe map is addressed straight from the incoming coordinate so its
   // one-cycle read lines up with the pixel sitting in stage 1.
   assign o_screen_x = i_h_coord[XW-1:0];
   assign o_screen_y = i_v_coord[YW-1:0];

   // Offsets are formed by zero-extending both operands before subtracting,
   // so a ball near an edge yields a genuine negative offset instead of
   // wrapping to the far side of the screen.
   always_comb begin
      for (int i = 0; i < N_BALLS; i++) begin
         dx_d[i] = DX_W'(i_h_coord) - DX_W'(i_ball_x[i*XW +: XW]);
         dy_d[i] = DY_W'(i_v_coord) - DY_W'(i_ball_y[i*YW +: YW]);
      end
      lastPix_d = (i_h_coord == LAST_H) && (i_v_coord == LAST_V);
   end

   // Stage 1: capture offsets, enables and the timing controls for this pixel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dx_q      <= '0;
         dy_q      <= '0;
         ballEn_q  <= '0;
         lastPix_q <= 1'b0;
         disp1_q   <= 1'b0;
         hsync1_q  <= 1'b0;
         vsync1_q  <= 1'b0;
      end else begin
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         ballEn_q  <= i_ball_en;
         lastPix_q <= lastPix_d;
         disp1_q   <= i_disp_enbl;
         hsync1_q  <= i_hsync;
         vsync1_q  <= i_vsync;
      end
   end

   for (genvar g = 0; g < N_BALLS; g++) begin : g_ball
      ball_hit_test #(
         .BALL_RADIUS (BALL_RADIUS)
      ) u_hit (
         .en_i        (ballEn_q[g]),
         .dx_i        (dx_q[g]),
         .dy_i        (dy_q[g]),
         .in_circle_o (inCircle[g])
      );
   end

   // Colour select: start from the map colour, then let balls overwrite it
   // walking from the highest index down so the lowest-index ball ends up on
   // top. Blanking overrides everything.
   always_comb begin
      color_d = i_is_safe ? SAFE_COLOR : BKG_COLOR;
      for (int i = N_BALLS - 1; i >= 0; i--) begin
         if (inCircle[i]) begin
            color_d = BALL_COLORS[i*12 +: 12];
         end
      end
      if (!disp1_q) begin
         color_d = '0;
      end
   end

   assign hit = inCircle & {N_BALLS{disp1_q && i_is_safe}};

   // Stage 2: register the colour and delayed controls, and run the per-frame
   // hit accumulator. On the last pixel the current hits go straight into the
   // published result while the accumulator restarts empty, so a hit on that
   // very pixel is reported once and never leaks into the next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         color_q     <= '0;
         disp2_q     <= 1'b0;
         hsync2_q    <= 1'b0;
         vsync2_q    <= 1'b0;
         acc_q       <= '0;
         safeHit_q   <= '0;
         frameDone_q <= 1'b0;
      end else begin
         color_q     <= color_d;
         disp2_q     <= disp1_q;
         hsync2_q    <= hsync1_q;
         vsync2_q    <= vsync1_q;
         frameDone_q <= lastPix_q;
         if (lastPix_q) begin
            safeHit_q <= acc_q | hit;
            acc_q     <= '0;
         end else begin
            acc_q     <= acc_q | hit;
         end
      end
   end

   assign colorSplit   = split_rgb(color_q);
   assign o_red        = colorSplit.r;
   assign o_green      = colorSplit.g;
   assign o_blue       = colorSplit.b;
   assign o_hsync      = hsync2_q;
   assign o_vsync      = vsync2_q;
   assign o_disp_enbl  = disp2_q;
   assign o_safe_hit   = safeHit_q;
   assign o_frame_done = frameDone_q;

endmodule

// File: tb/tb_graphic_multi_pipe.sv
// ---------------------------------------------------------------------------
// tb_graphic_multi_pipe
// Directed bench for graphic_multi_pipe with default parameters (800x600,
// four balls of radius 20). A small safe-map model answers one cycle after
// each address with 1 only at one configurable pixel.
// ---------------------------------------------------------------------------
module tb_graphic_multi_pipe;

   localparam int NB = 4;
   localparam int XW = 10;
   localparam int YW = 10;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_disp_enbl;
   logic [10:0]   i_h_coord;
   logic [9:0]    i_v_coord;
   logic          i_hsync;
   logic          i_vsync;
   logic [XW-1:0] o_screen_x;
   logic [YW-1:0] o_screen_y;
   logic          i_is_safe;
   logic [NB-1:0] i_ball_en;
   logic [NB*XW-1:0] i_ball_x;
   logic [NB*YW-1:0] i_ball_y;
   logic [3:0]    o_red;
   logic [3:0]    o_green;
   logic [3:0]    o_blue;
   logic          o_hsync;
   logic          o_vsync;
   logic          o_disp_enbl;
   logic [NB-1:0] o_safe_hit;
   logic          o_frame_done;

   int checks   = 0;
   int failures = 0;

   logic          safeEnable = 1'b0;
   logic [9:0]    safeX = '0;
   logic [9:0]    safeY = '0;

   always #5 i_clk = ~i_clk;

   // Safe-map model: synchronous read, data valid one cycle after address
   always @(posedge i_clk) begin
      i_is_safe <= safeEnable && (o_screen_x == safeX) && (o_screen_y == safeY);
   end

   graphic_multi_pipe dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_disp_enbl  (i_disp_enbl),
      .i_h_coord    (i_h_coord),
      .i_v_coord    (i_v_coord),
      .i_hsync      (i_hsync),
      .i_vsync      (i_vsync),
      .o_screen_x   (o_screen_x),
      .o_screen_y   (o_screen_y),
      .i_is_safe    (i_is_safe),
      .i_ball_en    (i_ball_en),
      .i_ball_x     (i_ball_x),
      .i_ball_y     (i_ball_y),
      .o_red        (o_red),
      .o_green      (o_green),
      .o_blue       (o_blue),
      .o_hsync      (o_hsync),
      .o_vsync      (o_vsync),
      .o_disp_enbl  (o_disp_enbl),
      .o_safe_hit   (o_safe_hit),
      .o_frame_done (o_frame_done)
   );

   // Drives one pixel's worth of timing-generator inputs
   task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                                input logic de, input logic hs, input logic vs);
      i_h_coord   = h;
      i_v_coord   = v;
      i_disp_enbl = de;
      i_hsync     = hs;
      i_vsync     = vs;
   endtask

   task automatic setBall(input int idx, input logic [9:0] x, input logic [9:0] y);
      i_ball_x[idx*XW +: XW] = x;
      i_ball_y[idx*YW +: YW] = y;
   endtask

   // Lets a held pixel reach the registered outputs, then settles off-edge
   task automatic waitPipe();
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   // Drives a sparse frame ending on the last visible pixel and reports any
   // o_frame_done pulses seen, with o_safe_hit captured at the pulse
   task automatic runFrame(output int pulses, output int pulseIdx, output logic [NB-1:0] hitSeen);
      int hList [7] = '{0, 300, 310, 799, 799, 0, 0};
      int vList [7] = '{0, 300, 300, 598, 599, 0, 0};
      pulses   = 0;
      pulseIdx = -1;
      hitSeen  = '0;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(11'(hList[k]), 10'(vList[k]), 1'b1, 1'b0, 1'b0);
         @(posedge i_clk);
         #1;
         if (o_frame_done) begin
            pulses++;
            pulseIdx = k;
            hitSeen  = o_safe_hit;
         end
      end
   endtask

   task automatic test_reset();
      i_rst_n   = 1'b0;
      i_ball_en = '0;
      i_ball_x  = '0;
      i_ball_y  = '0;
      applyStimulus(11'd300, 10'd200, 1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if ({o_red, o_green, o_blue, o_hsync, o_vsync, o_disp_enbl, o_safe_hit, o_frame_done} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got rgb=%h hs=%b vs=%b de=%b hit=%b fd=%b expected all zero",
                  {o_red, o_green, o_blue}, o_hsync, o_vsync, o_disp_enbl, o_safe_hit, o_frame_done);
      end
      checks++;
      if ({o_screen_x, o_screen_y} !== {10'd300, 10'd200}) begin
         failures++;
         $display("[TB] FAIL screen_addr: got x=%0d y=%0d expected x=300 y=200", o_screen_x, o_screen_y);
      end
      i_rst_n = 1'b1;
      applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   task automatic test_single_ball();
      logic [10:0] hTab [3] = '{11'd100, 11'd120, 11'd121};
      logic [11:0] expTab [3] = '{12'hF00, 12'hF00, 12'h00F};
      setBall(0, 10'd100, 10'd100);
      i_ball_en = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(hTab[k], 10'd100, 1'b1, 1'b0, 1'b0);
         waitPipe();
         checks++;
         if ({o_red, o_green, o_blue} !== expTab[k]) begin
            failures++;
            $display("[TB] FAIL single_ball_h%0d: got %h expected %h", hTab[k], {o_red, o_green, o_blue}, expTab[k]);
         end
      end
   endtask

   task automatic test_priority();
      setBall(0, 10'd200, 10'd200);
      setBall(1, 10'd200, 10'd200);
      i_ball_en = 4'b0011;
      applyStimulus(11'd200, 10'd200, 1'b1, 1'b0, 1'b0);
      waitPipe();
      checks++;
      if ({o_red, o_green, o_blue} !== 12'hF00) begin
         failures++;
         $display("[TB] FAIL priority_both: got %h expected f00", {o_red, o_green, o_blue});
      end
      i_ball_en = 4'b0010;
      waitPipe();
      checks++;
      if ({o_red, o_green, o_blue} !== 12'hFF0) begin
         failures++;
         $display("[TB] FAIL priority_ball1: got %h expected ff0", {o_red, o_green, o_blue});
      end
   endtask

   task automatic test_edge();
      setBall(0, 10'd5, 10'd5);
      i_ball_en = 4'b0001;
      applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      waitPipe();
      checks++;
      if ({o_red, o_green, o_blue} !== 12'hF00) begin
         failures++;
         $display("[TB] FAIL edge_corner: got %h expected f00", {o_red, o_green, o_blue});
      end
      applyStimulus(11'd795, 10'd5, 1'b1, 1'b0, 1'b0);
      waitPipe();
      checks++;
      if ({o_red, o_green, o_blue} !== 12'h00F) begin
         failures++;
         $display("[TB] FAIL edge_no_wrap: got %h expected 00f", {o_red, o_green, o_blue});
      end
   endtask

   task automatic test_disp_sync();
      logic [7:0] hsTab = 8'b0011_0100;
      logic [7:0] vsTab = 8'b0110_0010;
      logic [7:0] deTab = 8'b1100_1011;
      logic [2:0] expCtl;
      setBall(0, 10'd5, 10'd5);
      i_ball_en = 4'b0001;
      applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      waitPipe();
      checks++;
      if ({o_red, o_green, o_blue, o_disp_enbl} !== 13'h0) begin
         failures++;
         $display("[TB] FAIL blanked_ball: got rgb=%h de=%b expected rgb=000 de=0", {o_red, o_green, o_blue}, o_disp_enbl);
      end
      // Each value driven in iteration k must appear at the sample of k+1
      for (int k = 0; k < 8; k++) begin
         applyStimulus(11'd0, 10'd0, deTab[k], hsTab[k], vsTab[k]);
         @(posedge i_clk);
         #1;
         if (k > 0) begin
            expCtl = {hsTab[k-1], vsTab[k-1], deTab[k-1]};
            checks++;
            if ({o_hsync, o_vsync, o_disp_enbl} !== expCtl) begin
               failures++;
               $display("[TB] FAIL sync_delay_%0d: got hs/vs/de=%b expected %b", k, {o_hsync, o_vsync, o_disp_enbl}, expCtl);
            end
         end
      end
   endtask

   task automatic test_safe_hit();
      int pulses, pulseIdx;
      logic [NB-1:0] hitSeen;
      logic [NB-1:0] expHit [4] = '{4'b0100, 4'b0000, 4'b1000, 4'b0000};
      for (int f = 0; f < 4; f++) begin
         case (f)
            0: begin setBall(2, 10'd300, 10'd300); i_ball_en = 4'b0100; safeX = 10'd300; safeY = 10'd300; end
            1: begin setBall(2, 10'd100, 10'd100); i_ball_en = 4'b0100; end
            2: begin setBall(3, 10'd799, 10'd599); i_ball_en = 4'b1000; safeX = 10'd799; safeY = 10'd599; end
            default: i_ball_en = 4'b0000;
         endcase
         safeEnable = 1'b1;
         runFrame(pulses, pulseIdx, hitSeen);
         checks++;
         if (pulses !== 1 || pulseIdx !== 5) begin
            failures++;
            $display("[TB] FAIL frame%0d_done_pulse: got count=%0d at=%0d expected count=1 at=5", f, pulses, pulseIdx);
         end
         checks++;
         if (hitSeen !== expHit[f]) begin
            failures++;
            $display("[TB] FAIL frame%0d_safe_hit: got %b expected %b", f, hitSeen, expHit[f]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int pulses, pulseIdx;
      logic [NB-1:0] hitSeen;
      setBall(2, 10'd300, 10'd300);
      i_ball_en  = 4'b0100;
      safeX      = 10'd300;
      safeY      = 10'd300;
      safeEnable = 1'b1;
      applyStimulus(11'd300, 10'd300, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if ({o_red, o_green, o_blue, o_hsync} !== {12'hF0F, 1'b1}) begin
         failures++;
         $display("[TB] FAIL pre_reset_pixel: got rgb=%h hs=%b expected rgb=f0f hs=1", {o_red, o_green, o_blue}, o_hsync);
      end
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_red, o_green, o_blue, o_hsync, o_vsync, o_disp_enbl, o_safe_hit, o_frame_done} !== '0) begin
         failures++;
         $display("[TB] FAIL midframe_reset: got rgb=%h hs=%b vs=%b de=%b hit=%b fd=%b expected all zero",
                  {o_red, o_green, o_blue}, o_hsync, o_vsync, o_disp_enbl, o_safe_hit, o_frame_done);
      end
      @(posedge i_clk);
      #1;
      i_ball_en = 4'b0000;
      applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      i_rst_n = 1'b1;
      runFrame(pulses, pulseIdx, hitSeen);
      checks++;
      if (pulses !== 1 || pulseIdx !== 5) begin
         failures++;
         $display("[TB] FAIL post_reset_pulse: got count=%0d at=%0d expected count=1 at=5", pulses, pulseIdx);
      end
      checks++;
      if (hitSeen !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL post_reset_hit: got %b expected 0000", hitSeen);
      end
   endtask

   // Watchdog so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_ball();
      test_priority();
      test_edge();
      test_disp_sync();
      test_safe_hit();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/graphic_multi_pipe.md
Name: graphic_multi_pipe

Overview:
- Pipelined multi-ball pixel renderer for the VGA output path; successor to the single-ball combinational renderer.
- Draws up to N_BALLS circles with fixed priority over a safe-zone/background map, with registered RGB, sync and enable outputs.
- Accumulates a per-ball, per-frame "ball overlaps safe zone" flag for game logic.
- Sits between the VGA timing generator and the pins; drives the safe-map lookup address.

Parameters:
- SCREEN_WIDTH, 800, visible width; XW = $clog2(SCREEN_WIDTH).
- SCREEN_HEIGHT, 600, visible height; YW = $clog2(SCREEN_HEIGHT).
- N_BALLS, 4, number of balls, 1..8.
- BALL_RADIUS, 20, radius shared by all balls, 1..63.
- BALL_COLORS, {12'hF00,12'hFF0,12'hF0F,12'h0FF}, packed N_BALLS*12 bits; ball i colour is bits [12*i +: 12].
- SAFE_COLOR, 12'h0F0, safe-zone colour.
- BKG_COLOR, 12'h00F, background colour.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_disp_enbl  in  1  display enable from the timing generator.
- i_h_coord  in  11  horizontal pixel coordinate.
- i_v_coord  in  10  vertical pixel coordinate.
- i_hsync  in  1  horizontal sync, delayed to match the pipeline.
- i_vsync  in  1  vertical sync, delayed to match the pipeline.
- o_screen_x  out  XW  safe-map address, combinational: i_h_coord[XW-1:0].
- o_screen_y  out  YW  safe-map address, combinational: i_v_coord[YW-1:0].
- i_is_safe  in  1  safe-map data, valid exactly 1 cycle after its address.
- i_ball_en  in  N_BALLS  per-ball draw enable.
- i_ball_x  in  N_BALLS*XW  packed ball centre x.
- i_ball_y  in  N_BALLS*YW  packed ball centre y.
- o_red, o_green, o_blue  out  4 each  registered colour.
- o_hsync, o_vsync  out  1 each  syncs delayed by 2 cycles.
- o_disp_enbl  out  1  display enable delayed by 2 cycles.
- o_safe_hit  out  N_BALLS  bit i = ball i touched at least one safe pixel during the last complete frame.
- o_frame_done  out  1  one-cycle pulse when o_safe_hit updates.

Behaviour:
- Reset (async assert, sync release): all pipeline registers and outputs cleared to 0; syncs to 0; accumulators cleared.
- Stage 1 (cycle t -> t+1):
  - Register the signed diffs dx = h - bx (12-bit) and dy = v - by (11-bit) per ball.
  - Register disp_enbl, hsync, vsync, and a last-pixel flag (h == SCREEN_WIDTH-1 && v == SCREEN_HEIGHT-1).
  - Ball inputs are sampled at t; changing them mid-frame takes effect on the next pixel.
- Stage 2 (t+1 -> t+2):
  - in_i = ball_en_d[i] && dx*dx + dy*dy <= BALL_RADIUS^2, computed unsigned 24-bit, no truncation.
  - i_is_safe sampled here aligns with the stage-1 pixel.
  - Colour priority: !disp -> 000; else lowest-index in_i -> its colour; else is_safe -> SAFE_COLOR; else BKG_COLOR.
- Total latency: colour, syncs and o_disp_enbl lag the inputs by exactly 2 cycles.
- Hit accumulator acc[i] is set when disp && in_i && is_safe in stage 2.
  - When the last-pixel flag is in stage 2: o_safe_hit <= acc | current hits; acc <= 0; o_frame_done = 1 for that cycle.
  - Simultaneous set and clear on that cycle: the current hit is included in o_safe_hit and is not carried into the next frame.
- Balls at screen edges: negative diffs square correctly; partial circles are drawn clipped, with no wrap-around.
- Reset mid-frame: the partial frame is discarded; o_frame_done does not fire until a full last pixel is seen.

Decomposition:
- Package graphic_pkg: typedef rgb12_t (12-bit colour), the diff and distance width constants, and a function packing an rgb12_t into r/g/b.
- Sub-module ball_hit_test: one instance per ball; registered dx/dy in, combinational in_circle out. Instantiated with a generate loop.

Test Plan:
- Ball 0 at (100,100), enabled, not safe; drive pixel (100,100) -> 2 cycles later RGB = F00. Pixel (121,100) -> RGB = 00F.
- Balls 0 and 1 both at (200,200) -> RGB = F00. Disable ball 0 -> RGB = FF0 (ball 1 wins).
- Ball at (5,5) -> pixel (0,0) is drawn as ball (distance² 50 <= 400), with no spurious draw at (795,5).
- Safe map returns 1 only for pixel (300,300), ball 2 centred there, full frame -> o_frame_done pulses once 2 cycles after pixel (799,599); o_safe_hit = 4'b0100. Next frame with no overlap -> 4'b0000.
- i_disp_enbl = 0 with ball on pixel -> RGB = 000; hsync/vsync toggled -> outputs match, delayed 2 cycles.
- Assert i_rst_n low mid-frame -> all outputs 0 immediately. Release -> no o_frame_done until the next pixel (799,599).
